time_keeper: RTL and testbench

Real-time clock core for the wall-clock display path. It divides the system clock to a 1 Hz tick and maintains hours, minutes, seconds and AM/PM in binary. It supports a set mode driven by conditioned push-button pulses. Its outputs feed the seven-segment digit decoder directly, one field per port.

---
 rtl/time_pkg.sv | 43 ++++
 rtl/time_keeper_tick_gen.sv | 27 ++
 rtl/time_keeper.sv | 75 +++++++
 tb/tb_time_keeper.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/time_pkg.sv
// Shared field widths, limits and time record for the wall-clock path.
// TIME_KEEPER_24H_EN selects 0..23 hours with ampm tied low; default is 12-hour.
package time_pkg;

    localparam int unsigned TIME_W   = 6;
    localparam int unsigned SEC_MAX  = 59;
    localparam int unsigned MIN_MAX  = 59;
    localparam int unsigned HR12_MIN = 1;
    localparam int unsigned HR12_MAX = 12;
    localparam int unsigned HR24_MAX = 23;

    typedef struct packed {
        logic [TIME_W-1:0] hrs;
        logic [TIME_W-1:0] mins;
        logic [TIME_W-1:0] secs;
        logic              ampm;
    } time_t;

`ifdef TIME_KEEPER_24H_EN
    localparam time_t RESET_TIME = '{hrs: '0, mins: '0, secs: '0, ampm: 1'b0};

    function automatic time_t hr_step(input time_t t);
        time_t r;
        r      = t;
        r.hrs  = (t.hrs == TIME_W'(HR24_MAX)) ? '0 : t.hrs + TIME_W'(1);
        r.ampm = 1'b0;
        return r;
    endfunction
`else
    localparam time_t RESET_TIME = '{hrs: TIME_W'(HR12_MAX), mins: '0, secs: '0, ampm: 1'b0};

    // 12 -> 1 wraps without touching ampm; the 11 -> 12 step flips it.
    function automatic time_t hr_step(input time_t t);
        time_t r;
        r     = t;
        r.hrs = (t.hrs == TIME_W'(HR12_MAX)) ? TIME_W'(HR12_MIN) : t.hrs + TIME_W'(1);
        if (t.hrs == TIME_W'(HR12_MAX - 1))
            r.ampm = ~t.ampm;
        return r;
    endfunction
`endif

endpackage

// File: rtl/time_keeper_tick_gen.sv
// Prescaler dividing clk down to one terminal-count pulse per CLK_HZ counted cycles.
module tick_gen #(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic hold,
    input  logic clr,
    output logic tick_c
);

    localparam int unsigned CNT_W = $clog2(CLK_HZ);
    localparam logic [CNT_W-1:0] TC = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt;

    // A clear on the terminal cycle swallows the wrap, so no tick escapes.
    assign tick_c = !hold && !clr && (cnt == TC);

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (!hold)
            cnt <= (cnt == TC) ? '0 : cnt + CNT_W'(1);
    end

endmodule

// File: rtl/time_keeper.sv
// Real-time clock core: 1 Hz prescaler, h/m/s carry chain, button-driven set mode.
// TIME_KEEPER_24H_EN selects the 24-hour build (see time_pkg).
module time_keeper
    import time_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              set_mode,
    input  logic              inc_hr,
    input  logic              inc_min,
    input  logic              clr_sec,
    output logic [TIME_W-1:0] hrs,
    output logic [TIME_W-1:0] mins,
    output logic [TIME_W-1:0] secs,
    output logic              ampm,
    output logic              sec_tick
);

    time_t cur;
    time_t nxt;
    logic  tick_c;

    tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .hold   (!run || set_mode),
        .clr    (clr_sec),
        .tick_c (tick_c)
    );

    // Counted-second carry chain, then set-mode edits; set mode never sees a tick.
    always_comb begin
        nxt = cur;
        if (clr_sec) begin
            nxt.secs = '0;
        end else if (tick_c) begin
            if (cur.secs == TIME_W'(SEC_MAX)) begin
                nxt.secs = '0;
                if (cur.mins == TIME_W'(MIN_MAX)) begin
                    nxt.mins = '0;
                    nxt      = hr_step(nxt);
                end else begin
                    nxt.mins = cur.mins + TIME_W'(1);
                end
            end else begin
                nxt.secs = cur.secs + TIME_W'(1);
            end
        end
        if (set_mode) begin
            if (inc_hr)
                nxt = hr_step(nxt);
            if (inc_min)
                nxt.mins = (nxt.mins == TIME_W'(MIN_MAX)) ? '0 : nxt.mins + TIME_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur      <= RESET_TIME;
            sec_tick <= 1'b0;
        end else begin
            cur      <= nxt;
            sec_tick <= tick_c;
        end
    end

    assign hrs  = cur.hrs;
    assign mins = cur.mins;
    assign secs = cur.secs;
    assign ampm = cur.ampm;

endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper at CLK_HZ=4: constant corner-case table plus
// time-of-day reference sequences, checked through an expected-output queue.
module tb_time_keeper;

    localparam int unsigned CLK_HZ = 4;
`ifdef TIME_KEEPER_24H_EN
    localparam logic [5:0] RST_HR = 6'd0;
`else
    localparam logic [5:0] RST_HR = 6'd12;
`endif

    logic       clk = 1'b0;
    logic       rst, run, set_mode, inc_hr, inc_min, clr_sec;
    logic [5:0] hrs, mins, secs;
    logic       ampm, sec_tick;

    typedef struct packed {
        logic [5:0] hrs;
        logic [5:0] mins;
        logic [5:0] secs;
        logic       ampm;
        logic       tick;
    } out_t;

    typedef struct packed {
        logic rst, run, sm, ih, im, cs;
        out_t exp;
    } vec_t;

    out_t exp_q[$];
    vec_t tbl[6];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference state: 24-hour time of day plus prescaler position.
    int m_h = 0, m_m = 0, m_s = 0, m_pc = 0;

    time_keeper #(.CLK_HZ(CLK_HZ)) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .set_mode (set_mode),
        .inc_hr   (inc_hr),
        .inc_min  (inc_min),
        .clr_sec  (clr_sec),
        .hrs      (hrs),
        .mins     (mins),
        .secs     (secs),
        .ampm     (ampm),
        .sec_tick (sec_tick)
    );

    always #5 clk = ~clk;

    function automatic out_t model_out(input logic tick);
        out_t o;
`ifdef TIME_KEEPER_24H_EN
        o.hrs  = 6'(m_h);
        o.ampm = 1'b0;
`else
        o.hrs  = ((m_h % 12) == 0) ? 6'd12 : 6'(m_h % 12);
        o.ampm = (m_h >= 12);
`endif
        o.mins = 6'(m_m);
        o.secs = 6'(m_s);
        o.tick = tick;
        return o;
    endfunction

    task automatic model_step(input logic r, ru, sm, ih, im, cs, output out_t o);
        logic tick;
        int   tod;
        tick = 1'b0;
        if (r) begin
            m_h = 0; m_m = 0; m_s = 0; m_pc = 0;
        end else begin
            if (cs) begin
                m_s = 0; m_pc = 0;
            end else if (ru && !sm) begin
                if (m_pc == CLK_HZ - 1) begin
                    m_pc = 0;
                    tick = 1'b1;
                    tod  = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
                    m_h  = tod / 3600;
                    m_m  = (tod / 60) % 60;
                    m_s  = tod % 60;
                end else begin
                    m_pc = m_pc + 1;
                end
            end
            if (sm && ih) m_h = (m_h + 1) % 24;
            if (sm && im) m_m = (m_m + 1) % 60;
        end
        o = model_out(tick);
    endtask

    task automatic apply(input vec_t v, input string name);
        out_t got, e;
        rst = v.rst; run = v.run; set_mode = v.sm;
        inc_hr = v.ih; inc_min = v.im; clr_sec = v.cs;
        exp_q.push_back(v.exp);
        @(posedge clk);
        #1;
        got = {hrs, mins, secs, ampm, sec_tick};
        e   = exp_q.pop_front();
        n_vec++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d:%0d:%0d ampm=%0b tick=%0b, want %0d:%0d:%0d ampm=%0b tick=%0b",
                     name, $time, got.hrs, got.mins, got.secs, got.ampm, got.tick,
                     e.hrs, e.mins, e.secs, e.ampm, e.tick);
        end
    endtask

    task automatic drive(input logic r, ru, sm, ih, im, cs, input string name);
        vec_t v;
        out_t o;
        model_step(r, ru, sm, ih, im, cs, o);
        v = {r, ru, sm, ih, im, cs, o};
        apply(v, name);
    endtask

    task automatic run_cycles(input int n, input string name);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, name);
    endtask

    function automatic vec_t mk(input logic r, ru, sm, ih, im, cs,
                                input int h, mi, s, ap, tk);
        return {r, ru, sm, ih, im, cs, 6'(h), 6'(mi), 6'(s), 1'(ap), 1'(tk)};
    endfunction

    initial begin
        out_t dummy;
        rst = 1'b1; run = 1'b0; set_mode = 1'b0;
        inc_hr = 1'b0; inc_min = 1'b0; clr_sec = 1'b0;

        // Starting from 12:59:01 AM (00:59:01), prescaler held at 1.
        tbl[0] = mk(0, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0);        // all three pulses, no min->hr carry
        tbl[1] = mk(0, 1, 1, 1, 0, 0, 2, 0, 0, 0, 0);
        tbl[2] = mk(0, 1, 1, 0, 0, 0, 2, 0, 0, 0, 0);
        tbl[3] = mk(0, 0, 0, 1, 1, 0, 2, 0, 0, 0, 0);        // frozen: buttons ignored
        tbl[4] = mk(0, 1, 0, 0, 0, 0, 2, 0, 0, 0, 0);
        tbl[5] = mk(1, 1, 1, 1, 1, 1, int'(RST_HR), 0, 0, 0, 0); // reset beats pulses

        drive(1, 1, 0, 0, 0, 0, "reset");
        run_cycles(5, "first_second");
        for (int i = 0; i < 59; i++) drive(0, 1, 1, 0, 1, 0, "set_min");

        for (int i = 0; i < 6; i++) begin
            model_step(tbl[i].rst, tbl[i].run, tbl[i].sm, tbl[i].ih, tbl[i].im, tbl[i].cs, dummy);
            apply(tbl[i], $sformatf("table%0d", i));
        end

        for (int i = 0; i < 23; i++) drive(0, 1, 1, 1, 0, 0, "set_hr");
        drive(0, 1, 1, 1, 0, 0, "hr_wrap_pm_to_am");

        // Preset 11:59:00 AM, then count through to noon.
        for (int i = 0; i < 11; i++) drive(0, 1, 1, 1, 0, 0, "preset_hr");
        for (int i = 0; i < 59; i++) drive(0, 1, 1, 0, 1, 0, "preset_min");
        drive(0, 1, 1, 0, 0, 1, "preset_clr");
        run_cycles(58 * 4 + 8, "noon_rollover");

        // clr_sec collides with the tick that would carry 12:10:59 -> 12:11:00.
        for (int i = 0; i < 10; i++) drive(0, 1, 1, 0, 1, 0, "to_min10");
        drive(0, 1, 1, 0, 0, 1, "clr_in_set");
        run_cycles(59 * 4 + 3, "to_sec59");
        drive(0, 1, 0, 0, 0, 1, "clr_vs_tick");
        run_cycles(4, "after_clr");

        // Freeze mid-second with prescaler at 2.
        run_cycles(2, "to_pc2");
        for (int i = 0; i < 10; i++) drive(0, 0, 0, i[0], ~i[0], 0, "frozen");
        run_cycles(2, "resume");

        // 12:59:59 PM -> 1:00:00 PM.
        for (int i = 0; i < 49; i++) drive(0, 1, 1, 0, 1, 0, "to_min59");
        drive(0, 1, 1, 0, 0, 1, "clr_pm");
        run_cycles(59 * 4 + 4, "pm_hour_carry");

        // Reset mid-second drops the partial count.
        run_cycles(2, "partial");
        drive(1, 1, 0, 0, 0, 0, "reset_mid");
        run_cycles(4, "post_reset_second");

        // 11:59:59 PM (23:59:59) -> midnight.
        for (int i = 0; i < 23; i++) drive(0, 1, 1, 1, 0, 0, "to_hr23");
        for (int i = 0; i < 59; i++) drive(0, 1, 1, 0, 1, 0, "to_min59b");
        drive(0, 1, 1, 0, 0, 1, "clr_midnight");
        run_cycles(59 * 4 + 5, "midnight");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
